// File: rtl/div_unit.sv
// Iterative restoring divider for RV M-extension DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    input  logic             flush
);

    typedef enum logic [1:0] {IDLE, CALC, FAST, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, result_q;
    logic             op_rem_q, neg_quo_q, neg_rem_q, out_valid_q;

    logic             signed_op, sgn_a, sgn_b;
    logic [WIDTH:0]   shifted_d, trial_d;
    logic             take_d;
    logic [WIDTH-1:0] rem_d, quo_d;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = result_q;

    assign signed_op = ~in_op[0];
    assign sgn_a     = signed_op & in_dividend[WIDTH-1];
    assign sgn_b     = signed_op & in_divisor[WIDTH-1];

    // One restoring step: the (WIDTH+1)-bit difference's MSB is the borrow.
    assign shifted_d = {rem_q, quo_q[WIDTH-1]};
    assign trial_d   = shifted_d - {1'b0, dvs_q};
    assign take_d    = ~trial_d[WIDTH];
    assign rem_d     = take_d ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    assign quo_d     = {quo_q[WIDTH-2:0], take_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            result_q    <= '0;
            op_rem_q    <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_rem_q  <= in_op[1];
                        neg_quo_q <= sgn_a ^ sgn_b;
                        neg_rem_q <= sgn_a;
                        rem_q     <= '0;
                        quo_q     <= neg_if(in_dividend, sgn_a);
                        dvs_q     <= neg_if(in_divisor, sgn_b);
                        if (in_divisor == '0) begin
                            result_q <= in_op[1] ? in_dividend : '1;
                            state_q  <= FAST;
                        end else if (signed_op && in_dividend == MIN_VAL && in_divisor == '1) begin
                            result_q <= in_op[1] ? '0 : MIN_VAL;
                            state_q  <= FAST;
                        end else begin
                            cnt_q   <= CNT_W'(WIDTH);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q    <= op_rem_q ? neg_if(rem_d, neg_rem_q) : neg_if(quo_d, neg_quo_q);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                FAST: begin
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
